reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Holds issued ALU-class instructions (arith, branch, LUI/AUIPC/JAL/JALR) until both operands are available.
- Snoops the two common data buses (ALU and LSB) for tagged results.
- Each cycle, dispatches the oldest-index ready entry to the ALU through a registered output.
- Sits between the issue/decode stage (upstream) and the ALU (downstream).

Parameters:
- RS_SIZE, 16, number of entries (power of two, ≥2)
- TAG_W, 4, ROB tag width
- OP_W, 6, opcode width; opcode 0 is NOP

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-low
- rdy  in  1  global ready; low freezes all state
- flush  in  1  ROB misprediction clear
- iss_valid  in  1  issue request
- iss_op  in  OP_W  opcode
- iss_Vj, iss_Vk  in  32  operand values
- iss_Qj, iss_Qk  in  TAG_W  producer ROB tags
- iss_Rj, iss_Rk  in  1  operand ready flags (1 = V valid, Q ignored)
- iss_imm, iss_pc  in  32  immediate, instruction pc
- iss_rdTag  in  TAG_W  destination ROB tag
- full  out  1  no free entry
- alu_cdb_en  in  1  ALU bus valid
- alu_cdb_tag  in  TAG_W  ALU bus tag
- alu_cdb_val  in  32  ALU bus value
- lsb_cdb_en  in  1  LSB bus valid
- lsb_cdb_tag  in  TAG_W  LSB bus tag
- lsb_cdb_val  in  32  LSB bus value
- RS_valid  out  1  dispatch valid to ALU
- RS_op  out  OP_W  dispatched opcode
- RS_Vj, RS_Vk, RS_imm, RS_pc  out  32  dispatched fields
- RS_rdTag  out  TAG_W  dispatched destination tag

Behaviour:
- Entry state: busy, op, Vj, Vk, Rj, Rk, Qj, Qk, imm, pc, rdTag.
- Reset (rst==0 at posedge): all busy=0, RS_valid=0, RS_op=0, all other outputs 0. full=0 after reset.
- rdy==0: no state change; outputs hold their values; issue and CDB inputs are ignored.
- full: combinational, = all entries busy. Issue while full is dropped (no entry written, no state change).
- Issue: when iss_valid and !full, write the lowest-index free entry, busy=1.
- Issue-time forwarding: if Rj==0 and a CDB with en==1 has tag==iss_Qj this cycle, store Vj=that CDB's value and Rj=1. Same rule for k. If both buses match, ALU bus wins.
- Wakeup: every busy entry with Rj==0 and Qj matching an enabled CDB tag latches that value and sets Rj=1 at the posedge. Same rule for k. Both operands may wake in the same cycle, from either bus.
- Ready condition, evaluated on registered state only: busy && Rj && Rk. An entry woken or issued in cycle N can be selected no earlier than cycle N+1.
- Dispatch: each cycle, select the lowest-index ready entry.
  - At the posedge, copy its fields to the RS_* outputs, set RS_valid=1, and clear its busy bit.
  - If no entry is ready: RS_valid=0, RS_op=0.
  - Result: one-cycle output latency from selection; minimum issue-to-RS_valid is 2 cycles.
- Simultaneous events:
  - An entry freed by dispatch in cycle N is not reusable by issue in cycle N; full uses pre-dispatch busy bits.
  - Wakeup and dispatch of different entries proceed in parallel.
- flush (rdy==1): at the posedge, clear all busy bits and set RS_valid=0. Issue and wakeup in the same cycle are discarded. flush has priority over everything except reset.
- Reset mid-operation: same as the reset rule; in-flight outputs are cleared.

Optional Feature:
- Macro: RS_BYPASS_EN.
- Defined: if iss_valid, !full, both operands are ready at issue (including issue-time forwarding), and no stored entry is ready this cycle, the instruction is copied directly to the RS_* outputs at the next posedge (RS_valid=1) and no entry is allocated. Issue-to-RS_valid latency is 1 cycle.
- Undefined: every issue allocates an entry; latency is as in Behaviour.

Test Plan:
- Reset, then issue ADD (op=ADD, Vj=5, Vk=7, Rj=Rk=1, rdTag=3) -> 2 cycles later RS_valid=1, RS_op=ADD, RS_Vj=5, RS_Vk=7, RS_rdTag=3 (1 cycle with RS_BYPASS_EN); next cycle RS_valid=0.
- Issue SUB with Rj=0, Qj=2; 3 cycles later alu_cdb_en=1, tag=2, val=0x10 -> RS_valid=1 one cycle after the following selection cycle, RS_Vj=0x10; no dispatch before the CDB.
- Issue in the same cycle that lsb_cdb_tag==iss_Qk, lsb_cdb_val=0xABCD -> dispatched RS_Vk=0xABCD; no hang waiting for a second CDB.
- Fill all 16 entries with Rj=0, Qj=9 -> full=1; a 17th issue is dropped; one CDB with tag 9 -> entries dispatch in index order 0..15 on consecutive cycles; full drops after the first dispatch.
- Load 4 waiting entries, assert flush -> next cycle RS_valid=0, full=0; CDB tag match afterwards produces no dispatch.
- Hold rdy=0 for 3 cycles with a ready entry and an active CDB -> outputs and entries unchanged; behaviour resumes when rdy=1.

Source files
------------

// File: rtl/reservation_station.sv
// reservation_station
//   Holds issued ALU-class instructions until both source operands are
//   available. It snoops the ALU and LSB common data buses for tagged
//   results. Each cycle it dispatches the lowest-index ready entry to the
//   ALU through registered RS_* outputs.
//
// Ports
//   clk, rst        clock; synchronous active-low reset
//   rdy             global ready; low freezes all state
//   flush           misprediction clear (drops all entries and dispatch)
//   iss_*           issue request from decode (op, V/Q/R per operand,
//                   imm, pc, destination tag); full reports no free entry
//   alu_cdb_*       ALU result bus (en, tag, val)
//   lsb_cdb_*       LSB result bus (en, tag, val)
//   RS_*            registered dispatch to the ALU
//
// Build option
//   RS_BYPASS_EN    when defined, an issue whose operands are already
//                   ready goes straight to the RS_* outputs, but only if
//                   no stored entry is ready that cycle.
module reservation_station #(
  parameter int RS_SIZE = 16,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             iss_valid,
  input  logic [OP_W-1:0]  iss_op,
  input  logic [31:0]      iss_Vj,
  input  logic [31:0]      iss_Vk,
  input  logic [TAG_W-1:0] iss_Qj,
  input  logic [TAG_W-1:0] iss_Qk,
  input  logic             iss_Rj,
  input  logic             iss_Rk,
  input  logic [31:0]      iss_imm,
  input  logic [31:0]      iss_pc,
  input  logic [TAG_W-1:0] iss_rdTag,
  output logic             full,
  input  logic             alu_cdb_en,
  input  logic [TAG_W-1:0] alu_cdb_tag,
  input  logic [31:0]      alu_cdb_val,
  input  logic             lsb_cdb_en,
  input  logic [TAG_W-1:0] lsb_cdb_tag,
  input  logic [31:0]      lsb_cdb_val,
  output logic             RS_valid,
  output logic [OP_W-1:0]  RS_op,
  output logic [31:0]      RS_Vj,
  output logic [31:0]      RS_Vk,
  output logic [31:0]      RS_imm,
  output logic [31:0]      RS_pc,
  output logic [TAG_W-1:0] RS_rdTag
);

  localparam int IDX_W = $clog2(RS_SIZE);

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [TAG_W-1:0] tag;
  } payload_t;

  payload_t         pay_q [RS_SIZE];
  payload_t         pay_d [RS_SIZE];
  logic [TAG_W-1:0] qj_q  [RS_SIZE];
  logic [TAG_W-1:0] qj_d  [RS_SIZE];
  logic [TAG_W-1:0] qk_q  [RS_SIZE];
  logic [TAG_W-1:0] qk_d  [RS_SIZE];
  logic [RS_SIZE-1:0] busy_q, busy_d, rj_q, rj_d, rk_q, rk_d;

  payload_t out_q, out_d;
  logic     out_valid_q, out_valid_d;

  logic             any_ready, any_free;
  logic [IDX_W-1:0] sel_idx, free_idx;
  payload_t         new_pay;
  logic             new_rj, new_rk;

  assign full     = &busy_q;
  assign RS_valid = out_valid_q;
  assign RS_op    = out_q.op;
  assign RS_Vj    = out_q.vj;
  assign RS_Vk    = out_q.vk;
  assign RS_imm   = out_q.imm;
  assign RS_pc    = out_q.pc;
  assign RS_rdTag = out_q.tag;

  // Lowest-index ready and free entries, from registered state only.
  always_comb begin
    any_ready = 1'b0;
    any_free  = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (!any_ready && busy_q[i] && rj_q[i] && rk_q[i]) begin
        any_ready = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!any_free && !busy_q[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Incoming instruction with issue-time forwarding (ALU bus has priority).
  always_comb begin
    new_pay.op  = iss_op;
    new_pay.vj  = iss_Vj;
    new_pay.vk  = iss_Vk;
    new_pay.imm = iss_imm;
    new_pay.pc  = iss_pc;
    new_pay.tag = iss_rdTag;
    new_rj      = iss_Rj;
    new_rk      = iss_Rk;
    if (!iss_Rj) begin
      if (alu_cdb_en && alu_cdb_tag == iss_Qj) begin
        new_pay.vj = alu_cdb_val;
        new_rj     = 1'b1;
      end else if (lsb_cdb_en && lsb_cdb_tag == iss_Qj) begin
        new_pay.vj = lsb_cdb_val;
        new_rj     = 1'b1;
      end
    end
    if (!iss_Rk) begin
      if (alu_cdb_en && alu_cdb_tag == iss_Qk) begin
        new_pay.vk = alu_cdb_val;
        new_rk     = 1'b1;
      end else if (lsb_cdb_en && lsb_cdb_tag == iss_Qk) begin
        new_pay.vk = lsb_cdb_val;
        new_rk     = 1'b1;
      end
    end
  end

  always_comb begin
    pay_d       = pay_q;
    qj_d        = qj_q;
    qk_d        = qk_q;
    busy_d      = busy_q;
    rj_d        = rj_q;
    rk_d        = rk_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      busy_d      = '0;
      out_valid_d = 1'b0;
      out_d.op    = '0;
    end else begin
      // Wakeup of waiting operands.
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i] && !rj_q[i]) begin
          if (alu_cdb_en && alu_cdb_tag == qj_q[i]) begin
            pay_d[i].vj = alu_cdb_val;
            rj_d[i]     = 1'b1;
          end else if (lsb_cdb_en && lsb_cdb_tag == qj_q[i]) begin
            pay_d[i].vj = lsb_cdb_val;
            rj_d[i]     = 1'b1;
          end
        end
        if (busy_q[i] && !rk_q[i]) begin
          if (alu_cdb_en && alu_cdb_tag == qk_q[i]) begin
            pay_d[i].vk = alu_cdb_val;
            rk_d[i]     = 1'b1;
          end else if (lsb_cdb_en && lsb_cdb_tag == qk_q[i]) begin
            pay_d[i].vk = lsb_cdb_val;
            rk_d[i]     = 1'b1;
          end
        end
      end

      // Dispatch.
      if (any_ready) begin
        out_d           = pay_q[sel_idx];
        out_valid_d     = 1'b1;
        busy_d[sel_idx] = 1'b0;
      end else begin
        out_valid_d = 1'b0;
        out_d.op    = '0;
      end

      // Issue; the free slot comes from pre-dispatch busy bits, so it never
      // collides with the entry being dispatched.
      if (iss_valid && !full) begin
`ifdef RS_BYPASS_EN
        if (new_rj && new_rk && !any_ready) begin
          out_d       = new_pay;
          out_valid_d = 1'b1;
        end else begin
          pay_d[free_idx]  = new_pay;
          qj_d[free_idx]   = iss_Qj;
          qk_d[free_idx]   = iss_Qk;
          rj_d[free_idx]   = new_rj;
          rk_d[free_idx]   = new_rk;
          busy_d[free_idx] = 1'b1;
        end
`else
        pay_d[free_idx]  = new_pay;
        qj_d[free_idx]   = iss_Qj;
        qk_d[free_idx]   = iss_Qk;
        rj_d[free_idx]   = new_rj;
        rk_d[free_idx]   = new_rk;
        busy_d[free_idx] = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q      <= '0;
      rj_q        <= '0;
      rk_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        pay_q[i] <= '0;
        qj_q[i]  <= '0;
        qk_q[i]  <= '0;
      end
    end else if (rdy) begin
      busy_q      <= busy_d;
      rj_q        <= rj_d;
      rk_q        <= rk_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      pay_q       <= pay_d;
      qj_q        <= qj_d;
      qk_q        <= qk_d;
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Testbench for reservation_station: directed scenarios followed by random
// traffic, all checked every cycle against an entry-list reference model.
module tb_reservation_station;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, iss_valid, iss_Rj, iss_Rk;
  logic [5:0]  iss_op;
  logic [31:0] iss_Vj, iss_Vk, iss_imm, iss_pc;
  logic [3:0]  iss_Qj, iss_Qk, iss_rdTag;
  logic        alu_cdb_en, lsb_cdb_en;
  logic [3:0]  alu_cdb_tag, lsb_cdb_tag;
  logic [31:0] alu_cdb_val, lsb_cdb_val;
  logic        full, RS_valid;
  logic [5:0]  RS_op;
  logic [31:0] RS_Vj, RS_Vk, RS_imm, RS_pc;
  logic [3:0]  RS_rdTag;

  always #5 clk = ~clk;

  reservation_station #(.RS_SIZE(16), .TAG_W(4), .OP_W(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .iss_valid(iss_valid), .iss_op(iss_op), .iss_Vj(iss_Vj), .iss_Vk(iss_Vk),
    .iss_Qj(iss_Qj), .iss_Qk(iss_Qk), .iss_Rj(iss_Rj), .iss_Rk(iss_Rk),
    .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_rdTag(iss_rdTag), .full(full),
    .alu_cdb_en(alu_cdb_en), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_val(alu_cdb_val),
    .lsb_cdb_en(lsb_cdb_en), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_val(lsb_cdb_val),
    .RS_valid(RS_valid), .RS_op(RS_op), .RS_Vj(RS_Vj), .RS_Vk(RS_Vk),
    .RS_imm(RS_imm), .RS_pc(RS_pc), .RS_rdTag(RS_rdTag)
  );

  // Reference model: a list of held instructions plus the output register.
  typedef struct {
    bit        busy;
    bit [5:0]  op;
    bit [31:0] vj, vk, imm, pc;
    bit        rj, rk;
    bit [3:0]  qj, qk, tag;
  } ment_t;

  ment_t     m [N];
  bit        mo_valid;
  bit [5:0]  mo_op;
  bit [31:0] mo_vj, mo_vk, mo_imm, mo_pc;
  bit [3:0]  mo_tag;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Value seen by a waiting operand this cycle (ALU bus takes priority).
  function automatic void snoop(input bit r, input bit [3:0] q, input bit [31:0] v,
                                output bit ro, output bit [31:0] vo);
    ro = r;
    vo = v;
    if (!r) begin
      if (alu_cdb_en && alu_cdb_tag == q) begin ro = 1; vo = alu_cdb_val; end
      else if (lsb_cdb_en && lsb_cdb_tag == q) begin ro = 1; vo = lsb_cdb_val; end
    end
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < N; i++) if (!m[i].busy) return 0;
    return 1;
  endfunction

  function automatic void model_step();
    ment_t nx [N];
    int    pick, slot;
    ment_t ni;
    if (!rst) begin
      foreach (m[i]) m[i].busy = 0;
      mo_valid = 0; mo_op = 0; mo_vj = 0; mo_vk = 0; mo_imm = 0; mo_pc = 0; mo_tag = 0;
      return;
    end
    if (!rdy) return;
    if (flush) begin
      foreach (m[i]) m[i].busy = 0;
      mo_valid = 0; mo_op = 0;
      return;
    end
    nx = m;
    pick = -1;
    slot = -1;
    for (int i = 0; i < N; i++) begin
      if (pick < 0 && m[i].busy && m[i].rj && m[i].rk) pick = i;
      if (slot < 0 && !m[i].busy) slot = i;
      if (m[i].busy) begin
        snoop(m[i].rj, m[i].qj, m[i].vj, nx[i].rj, nx[i].vj);
        snoop(m[i].rk, m[i].qk, m[i].vk, nx[i].rk, nx[i].vk);
      end
    end
    if (pick >= 0) begin
      mo_valid = 1; mo_op = m[pick].op; mo_vj = m[pick].vj; mo_vk = m[pick].vk;
      mo_imm = m[pick].imm; mo_pc = m[pick].pc; mo_tag = m[pick].tag;
      nx[pick].busy = 0;
    end else begin
      mo_valid = 0; mo_op = 0;
    end
    if (iss_valid && slot >= 0) begin
      ni.busy = 1; ni.op = iss_op; ni.imm = iss_imm; ni.pc = iss_pc;
      ni.tag = iss_rdTag; ni.qj = iss_Qj; ni.qk = iss_Qk;
      snoop(iss_Rj, iss_Qj, iss_Vj, ni.rj, ni.vj);
      snoop(iss_Rk, iss_Qk, iss_Vk, ni.rk, ni.vk);
`ifdef RS_BYPASS_EN
      if (ni.rj && ni.rk && pick < 0) begin
        mo_valid = 1; mo_op = ni.op; mo_vj = ni.vj; mo_vk = ni.vk;
        mo_imm = ni.imm; mo_pc = ni.pc; mo_tag = ni.tag;
      end else nx[slot] = ni;
`else
      nx[slot] = ni;
`endif
    end
    m = nx;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("full", full, model_full());
    check("RS_valid", RS_valid, mo_valid);
    check("RS_op", RS_op, mo_op);
    check("RS_Vj", RS_Vj, mo_vj);
    check("RS_Vk", RS_Vk, mo_vk);
    check("RS_imm", RS_imm, mo_imm);
    check("RS_pc", RS_pc, mo_pc);
    check("RS_rdTag", RS_rdTag, mo_tag);
  endtask

  task automatic idle();
    rst = 1; rdy = 1; flush = 0; iss_valid = 0;
    iss_op = 0; iss_Vj = 0; iss_Vk = 0; iss_Qj = 0; iss_Qk = 0;
    iss_Rj = 1; iss_Rk = 1; iss_imm = 0; iss_pc = 0; iss_rdTag = 0;
    alu_cdb_en = 0; alu_cdb_tag = 0; alu_cdb_val = 0;
    lsb_cdb_en = 0; lsb_cdb_tag = 0; lsb_cdb_val = 0;
  endtask

  task automatic issue(input bit [5:0] op, input bit [31:0] vj, input bit [31:0] vk,
                       input bit rj, input bit [3:0] qj, input bit rk, input bit [3:0] qk,
                       input bit [3:0] tag);
    iss_valid = 1; iss_op = op; iss_Vj = vj; iss_Vk = vk;
    iss_Rj = rj; iss_Qj = qj; iss_Rk = rk; iss_Qk = qk; iss_rdTag = tag;
    iss_imm = 32'h100 + {28'd0, tag}; iss_pc = 32'h8000 + {26'd0, op};
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin idle(); tick(); end
  endtask

  initial begin
    idle();
    rst = 0;
    tick(); tick();
    check("full after reset", full, 1'b0);

    // ADD with both operands ready.
    idle(); issue(6'd1, 32'd5, 32'd7, 1, 4'd0, 1, 4'd0, 4'd3); tick();
    idle_cycles(3);

    // SUB waiting on tag 2, woken by the ALU bus three cycles later.
    idle(); issue(6'd2, 32'd0, 32'd9, 0, 4'd2, 1, 4'd0, 4'd4); tick();
    idle_cycles(2);
    idle(); alu_cdb_en = 1; alu_cdb_tag = 4'd2; alu_cdb_val = 32'h10; tick();
    idle_cycles(3);

    // Issue-time forwarding from the LSB bus.
    idle(); issue(6'd3, 32'd1, 32'd0, 1, 4'd0, 0, 4'd5, 4'd6);
    lsb_cdb_en = 1; lsb_cdb_tag = 4'd5; lsb_cdb_val = 32'hABCD; tick();
    idle_cycles(3);

    // Fill every entry on tag 9, try a 17th issue, then release them all.
    for (int i = 0; i < N + 1; i++) begin
      idle(); issue(6'(i + 8), 32'd0, 32'(i), 0, 4'd9, 1, 4'd0, 4'(i)); tick();
    end
    check("full when filled", full, 1'b1);
    idle(); alu_cdb_en = 1; alu_cdb_tag = 4'd9; alu_cdb_val = 32'h99; tick();
    idle_cycles(N + 2);

    // Flush with waiting entries; a later matching CDB must find nothing.
    for (int i = 0; i < 4; i++) begin
      idle(); issue(6'd20, 32'd0, 32'd0, 0, 4'd11, 1, 4'd0, 4'(i)); tick();
    end
    idle(); flush = 1; tick();
    check("full after flush", full, 1'b0);
    idle(); alu_cdb_en = 1; alu_cdb_tag = 4'd11; alu_cdb_val = 32'h55; tick();
    idle_cycles(3);

    // Freeze with rdy low while a ready entry and an active CDB exist.
    idle(); issue(6'd4, 32'd1, 32'd2, 1, 4'd0, 0, 4'd7, 4'd8); tick();
    idle(); issue(6'd5, 32'd3, 32'd4, 1, 4'd0, 1, 4'd0, 4'd9); tick();
    for (int i = 0; i < 3; i++) begin
      idle(); rdy = 0; issue(6'd6, 32'd5, 32'd6, 1, 4'd0, 1, 4'd0, 4'd10);
      alu_cdb_en = 1; alu_cdb_tag = 4'd7; alu_cdb_val = 32'h77; tick();
    end
    idle(); alu_cdb_en = 1; alu_cdb_tag = 4'd7; alu_cdb_val = 32'h78; tick();
    idle_cycles(4);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      idle();
      rst   = ($urandom_range(0, 199) != 0);
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 39) == 0);
      iss_valid = ($urandom_range(0, 9) < 6);
      iss_op = 6'($urandom); iss_Vj = $urandom; iss_Vk = $urandom;
      iss_Qj = 4'($urandom); iss_Qk = 4'($urandom);
      iss_Rj = 1'($urandom); iss_Rk = 1'($urandom);
      iss_imm = $urandom; iss_pc = $urandom; iss_rdTag = 4'($urandom);
      alu_cdb_en = 1'($urandom); alu_cdb_tag = 4'($urandom); alu_cdb_val = $urandom;
      lsb_cdb_en = 1'($urandom); lsb_cdb_tag = 4'($urandom); lsb_cdb_val = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
